// File: rtl/dot_product_seq.sv
// dot_product_seq: streams len 32-bit word pairs through one popcount(a & b)
// unit and accumulates the per-word counts into a single result.
module dot_product32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [5:0]  dot
);
  logic [31:0] both;

  assign both = a & b;

  always_comb begin
    dot = '0;
    for (int i = 0; i < 32; i++) begin
      dot = dot + 6'(both[i]);
    end
  end
endmodule

module dot_product_seq #(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4,
  parameter int ACC_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_result,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [CNT_W-1:0] len_clamp;
  logic [5:0]       dot;
  logic             beat;

  dot_product32 u_dot (
    .a   (in_a),
    .b   (in_b),
    .dot (dot)
  );

  // Handshake outputs are pure state decodes: no input-to-output paths.
  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = acc;

  assign beat      = in_valid && in_ready;
  assign len_clamp = (len > MAX_CNT) ? MAX_CNT : len;

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    remaining_n = remaining;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_n = '0;
          if (len_clamp == '0) begin
            remaining_n = '0;
            state_n     = DONE;
          end else begin
            remaining_n = len_clamp;
            state_n     = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          acc_n       = '0;
          remaining_n = '0;
          state_n     = IDLE;
        end else if (beat) begin
          acc_n       = acc + ACC_W'(dot);
          remaining_n = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          acc_n       = '0;
          remaining_n = '0;
          state_n     = IDLE;
        end else if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        acc_n       = '0;
        remaining_n = '0;
        state_n     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      remaining <= remaining_n;
    end
  end
endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: directed plus randomized jobs, checked every cycle
// against a job-level behavioural model of the sequencer.
module tb_dot_product_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [8:0]  out_result;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0 = waiting for a job, 1 = collecting words, 2 = holding result
  int m_phase = 0;
  int m_left  = 0;
  int m_sum   = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;

  dot_product_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = 0;
      armed   = 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_sum   = 0;
        m_left  = (int'(len) > 8) ? 8 : int'(len);
        m_phase = (m_left == 0) ? 2 : 1;
      end
    end else if (abort) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = 0;
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_sum  = m_sum + $countones(in_a & in_b);
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 1));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("out_result", 32'(out_result), 32'(m_sum));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int beats;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(out_result), 32'd0);

    // three words: 32 + 0 + 16
    start = 1'b1; len = 4'd3; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; tick();
    in_a = 32'h0000FFFF; in_b = 32'hFFFF0000; tick();
    check("t1_not_early", 32'(out_valid), 32'd0);
    in_a = 32'hAAAAAAAA; in_b = 32'hFFFFFFFF; tick();
    in_valid = 1'b0;
    check("t1_latency", 32'(out_valid), 32'd1);
    check("t1_result", 32'(out_result), 32'd48);
    check("t1_model", 32'(m_sum), 32'd48);
    repeat (2) tick();
    check("t1_hold", 32'(out_result), 32'd48);
    handshake();
    check("t1_idle", 32'(busy), 32'd0);

    // eight all-ones words with gaps
    start = 1'b1; len = 4'd8; tick(); start = 1'b0;
    in_a = '1; in_b = '1;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      in_valid = (i % 2) == 0;
      tick();
    end
    in_valid = 1'b0;
    check("t2_done", 32'(out_valid), 32'd1);
    check("t2_result", 32'(out_result), 32'd256);
    handshake();

    // empty job
    start = 1'b1; len = 4'd0; tick(); start = 1'b0;
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_result", 32'(out_result), 32'd0);
    check("t3_ready", 32'(in_ready), 32'd0);
    handshake();

    // oversize job is clamped
    start = 1'b1; len = 4'd15; tick(); start = 1'b0;
    in_valid = 1'b1;
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) beats++;
      in_a = $urandom; in_b = $urandom;
      tick();
    end
    check("t4_beats", 32'(beats), 32'd8);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    handshake();

    // abort with a beat offered in the same cycle
    start = 1'b1; len = 4'd4; tick(); start = 1'b0;
    in_valid = 1'b1; in_a = '1; in_b = '1;
    repeat (2) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    in_valid = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_result", 32'(out_result), 32'd0);
    repeat (3) tick();
    start = 1'b1; len = 4'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_a = 32'h0000000F; in_b = 32'h00000003; tick();
    in_valid = 1'b0;
    check("t5_valid2", 32'(out_valid), 32'd1);
    check("t5_result2", 32'(out_result), 32'd2);
    handshake();

    // start during the output handshake is ignored
    start = 1'b1; len = 4'd0; tick(); start = 1'b0;
    out_ready = 1'b1; start = 1'b1; len = 4'd2; tick();
    out_ready = 1'b0; start = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);

    // reset mid-job
    start = 1'b1; len = 4'd5; tick(); start = 1'b0;
    in_valid = 1'b1; in_a = '1; in_b = '1; tick();
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("t7_ready", 32'(in_ready), 32'd0);
    check("t7_valid", 32'(out_valid), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_result", 32'(out_result), 32'd0);

    for (int i = 0; i < 600; i++) begin
      reset     = $urandom_range(0, 199) == 0;
      start     = $urandom_range(0, 3) == 0;
      len       = 4'($urandom_range(0, 15));
      abort     = $urandom_range(0, 29) == 0;
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 1) == 1;
      in_a      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      in_b      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      tick();
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
